dff_bank_seq: RTL

Sequencer for a bank of WIDTH edge-triggered D flip-flops with active-low asynchronous preset/clear. It turns single commands into cycle-exact control: parallel load strobes, stretched preset/clear pulses with a recovery gap, and multi-cycle serial shifts. It sits between a command source using a valid/ready handshake and the flip-flop bank, and keeps a shadow copy of the value the bank holds.

---
 rtl/dff_bank_seq.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/dff_bank_seq.sv
// Sequencer driving a D flip-flop bank: load strobes, preset/clear pulses, shifts.
// Keeps a shadow copy of the bank contents in bank_val.
module dff_bank_seq #(
  parameter int WIDTH   = 8,
  parameter int PULSE_W = 2,
  parameter int RECOV   = 1,
  parameter int CW      = 4
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic [CW-1:0]    cmd_cnt,
  output logic [WIDTH-1:0] bank_d,
  output logic             bank_ce,
  output logic             bank_prn,
  output logic             bank_clrn,
  output logic [WIDTH-1:0] bank_val,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam int KW =
    CW + $clog2(WIDTH + PULSE_W + RECOV + 1);

  localparam logic [KW-1:0] W_K  = KW'(WIDTH);
  localparam logic [KW-1:0] PW_K = KW'(PULSE_W - 1);
  localparam logic [KW-1:0] RC_K =
    KW'((RECOV > 0) ? RECOV - 1 : 0);

  localparam logic [2:0] OP_NOP = 3'b000;
  localparam logic [2:0] OP_LD  = 3'b001;
  localparam logic [2:0] OP_CLR = 3'b010;
  localparam logic [2:0] OP_PRE = 3'b011;
  localparam logic [2:0] OP_SHL = 3'b100;
  localparam logic [2:0] OP_SHR = 3'b101;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_PULSE, S_RECOV, S_SHIFT
  } state_t;

  state_t          state_q, state_n;
  logic [KW-1:0]   cnt_q, cnt_n, n_k;
  logic            dir_q, dir_n;
  logic            fill_q, fill_n;
  logic [WIDTH-1:0] d_n, val_n;
  logic            ce_n, prn_n, clrn_n;
  logic            done_n, err_n, acc;

  // dir 0 shifts left, 1 shifts right; fill enters the vacated end
  function automatic logic [WIDTH-1:0] shift_f(
    input logic [WIDTH-1:0] v,
    input logic             dir,
    input logic             fill
  );
    if (dir) shift_f = {fill, v[WIDTH-1:1]};
    else     shift_f = {v[WIDTH-2:0], fill};
  endfunction

  assign cmd_ready = (state_q == S_IDLE) & ~clr;
  assign busy      = (state_q != S_IDLE);
  assign acc       = cmd_valid & cmd_ready;
  assign n_k       = (KW'(cmd_cnt) > W_K) ?
                     W_K : KW'(cmd_cnt);

  always_comb begin
    state_n = state_q;
    cnt_n   = cnt_q;
    dir_n   = dir_q;
    fill_n  = fill_q;
    d_n     = bank_d;
    val_n   = bank_val;
    ce_n    = 1'b0;
    prn_n   = 1'b1;
    clrn_n  = 1'b1;
    done_n  = 1'b0;
    err_n   = 1'b0;
    unique case (state_q)
      S_IDLE: if (acc) begin
        unique case (1'b1)
          (cmd_op == OP_NOP): done_n = 1'b1;
          (cmd_op == OP_LD): begin
            state_n = S_LOAD;
            d_n     = cmd_data;
            val_n   = cmd_data;
            ce_n    = 1'b1;
          end
          (cmd_op == OP_CLR),
          (cmd_op == OP_PRE): begin
            state_n = S_PULSE;
            cnt_n   = PW_K;
            prn_n   = ~cmd_op[0];
            clrn_n  = cmd_op[0];
            val_n   = {WIDTH{cmd_op[0]}};
          end
          (cmd_op == OP_SHL),
          (cmd_op == OP_SHR): begin
            if (n_k == '0) begin
              done_n = 1'b1;
            end else begin
              state_n = S_SHIFT;
              cnt_n   = n_k - 1'b1;
              dir_n   = cmd_op[0];
              fill_n  = cmd_data[0];
              d_n     = shift_f(bank_val, cmd_op[0],
                                cmd_data[0]);
              val_n   = d_n;
              ce_n    = 1'b1;
            end
          end
          default: err_n = 1'b1;
        endcase
      end
      S_LOAD: begin
        state_n = S_IDLE;
        done_n  = 1'b1;
      end
      S_PULSE: begin
        if (cnt_q == '0) begin
          if (RECOV == 0) begin
            state_n = S_IDLE;
            done_n  = 1'b1;
          end else begin
            state_n = S_RECOV;
            cnt_n   = RC_K;
          end
        end else begin
          cnt_n  = cnt_q - 1'b1;
          prn_n  = bank_prn;
          clrn_n = bank_clrn;
        end
      end
      S_RECOV: begin
        if (cnt_q == '0) begin
          state_n = S_IDLE;
          done_n  = 1'b1;
        end else begin
          cnt_n = cnt_q - 1'b1;
        end
      end
      S_SHIFT: begin
        if (cnt_q == '0) begin
          state_n = S_IDLE;
          done_n  = 1'b1;
        end else begin
          cnt_n = cnt_q - 1'b1;
          d_n   = shift_f(bank_val, dir_q, fill_q);
          val_n = d_n;
          ce_n  = 1'b1;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      dir_q     <= 1'b0;
      fill_q    <= 1'b0;
      bank_d    <= '0;
      bank_val  <= '0;
      bank_ce   <= 1'b0;
      bank_prn  <= 1'b1;
      bank_clrn <= 1'b1;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      state_q   <= state_n;
      cnt_q     <= cnt_n;
      dir_q     <= dir_n;
      fill_q    <= fill_n;
      bank_d    <= d_n;
      bank_val  <= val_n;
      bank_ce   <= ce_n;
      bank_prn  <= prn_n;
      bank_clrn <= clrn_n;
      done      <= done_n;
      err       <= err_n;
    end
  end

endmodule
